// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: owns the pc and feeds decode through a one-entry registered stage.
// The stage loads one cycle after the pc is presented; the pc holds while the stage is full and instr_ready is low.
module fetch_sequencer #(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  done,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] LAST_PC  = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [15:0]           fetch_count_q, fetch_count_d;
  logic                  xfer;
  logic                  load;

  assign xfer = instr_valid_q & instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;
    load          = 1'b0;

    // A handshake always completes, even on the cycle of a flush.
    if (xfer) begin
      fetch_count_d = fetch_count_q + 16'd1;
      instr_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RUN;
          pc_d          = START_PC;
          fetch_count_d = '0;
        end
      end
      S_RUN: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = halt ? S_DRAIN : S_RUN;
        end else if (halt) begin
          state_d = S_DRAIN;
        end else begin
          load = !instr_valid_q || xfer;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          state_d       = S_RUN;
        end else if (!instr_valid_q || xfer) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The top word ends the program: pc parks there instead of wrapping to 0.
    if (load) begin
      instr_d       = imem_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
      if (pc_q == LAST_PC) begin
        state_d = S_DRAIN;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign done        = (state_q == S_DONE);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        halt;
  logic        done;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .done        (done),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input int k);
    logic [5:0] a;
    a = 6'(k);
    return {16'hC0DE, 10'd0, a};
  endfunction

  assign imem_data = word(int'(imem_addr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int exp_pc, input int exp_cnt);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_pc"},    32'(instr_pc),    32'(exp_pc));
    chk({tag, "_instr"}, instr,            word(exp_pc));
    chk({tag, "_count"}, 32'(fetch_count), 32'(exp_cnt));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr,            32'd0);
    chk({tag, "_ipc"},   32'(instr_pc),    32'd0);
    chk({tag, "_count"}, 32'(fetch_count), 32'd0);
    chk({tag, "_done"},  32'(done),        32'd0);
    chk({tag, "_addr"},  32'(imem_addr),   32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #3;
    chk_reset("reset");
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_no_fetch", 32'(instr_valid), 32'd0);

    // Start and stream with instr_ready high
    start = 1'b1; instr_ready = 1'b1;
    step();
    start = 1'b0;
    chk("start_empty", 32'(instr_valid), 32'd0);
    chk("start_addr",  32'(imem_addr),   32'd0);
    for (int n = 1; n <= 5; n++) begin
      step(); chk_out("stream", n - 1, n - 1);
    end
    chk("pc_ahead", 32'(imem_addr), 32'd5);

    // Backpressure holding word 4
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_out("bp_hold", 4, 4);
      chk("bp_addr", 32'(imem_addr), 32'd5);
    end
    instr_ready = 1'b1;
    for (int k = 5; k <= 10; k++) begin
      step(); chk_out("bp_release", k, k);
    end

    // Redirect with a concurrent transfer: the transfer still counts
    redirect = 1'b1; redirect_pc = 6'd7;
    step();
    redirect = 1'b0;
    chk("redir1_valid", 32'(instr_valid), 32'd0);
    chk("redir1_count", 32'(fetch_count), 32'd11);
    chk("redir1_addr",  32'(imem_addr),   32'd7);
    instr_ready = 1'b0;
    step(); chk_out("redir1_word", 7, 11);

    // Redirect to 0x20 while word 7 is stalled: word 7 is dropped
    redirect = 1'b1; redirect_pc = 6'h20;
    step();
    redirect = 1'b0; instr_ready = 1'b1;
    chk("redir2_valid", 32'(instr_valid), 32'd0);
    chk("redir2_count", 32'(fetch_count), 32'd11);
    chk("redir2_addr",  32'(imem_addr),   32'h20);
    step(); chk_out("redir2_w20", 32, 11);
    step(); chk_out("redir2_w21", 33, 12);

    // End of memory
    redirect = 1'b1; redirect_pc = 6'd60;
    step();
    redirect = 1'b0;
    chk("eom_flush_valid", 32'(instr_valid), 32'd0);
    chk("eom_flush_count", 32'(fetch_count), 32'd13);
    for (int k = 60; k <= 63; k++) begin
      step(); chk_out("eom", k, k - 47);
    end
    chk("eom_pc_parked", 32'(imem_addr), 32'd63);
    chk("eom_not_done",  32'(done),      32'd0);
    step();
    chk("eom_done",  32'(done),        32'd1);
    chk("eom_valid", 32'(instr_valid), 32'd0);
    chk("eom_count", 32'(fetch_count), 32'd17);
    chk("eom_nowrap", 32'(imem_addr),  32'd63);
    redirect = 1'b1; redirect_pc = 6'd5;
    step();
    redirect = 1'b0;
    chk("done_redir_ignored_done", 32'(done),        32'd1);
    chk("done_redir_ignored_addr", 32'(imem_addr),   32'd63);
    chk("done_redir_ignored_vld",  32'(instr_valid), 32'd0);

    // Restart from DONE
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_done",  32'(done),        32'd0);
    chk("restart_count", 32'(fetch_count), 32'd0);
    chk("restart_addr",  32'(imem_addr),   32'd0);
    step(); chk_out("restart_w0", 0, 0);
    step(); chk_out("restart_w1", 1, 1);

    // halt and redirect together
    halt = 1'b1; redirect = 1'b1; redirect_pc = 6'd9;
    step();
    halt = 1'b0; redirect = 1'b0;
    chk("hr_valid", 32'(instr_valid), 32'd0);
    chk("hr_count", 32'(fetch_count), 32'd2);
    chk("hr_not_done", 32'(done), 32'd0);
    step();
    chk("hr_done",   32'(done),        32'd1);
    chk("hr_valid2", 32'(instr_valid), 32'd0);
    step();
    chk("hr_done_hold", 32'(done),        32'd1);
    chk("hr_count2",    32'(fetch_count), 32'd2);

    // halt with an instruction held under backpressure
    start = 1'b1; instr_ready = 1'b0;
    step();
    start = 1'b0;
    chk("halt_restart_count", 32'(fetch_count), 32'd0);
    step(); chk_out("halt_w0", 0, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    chk_out("halt_held", 0, 0);
    chk("halt_not_done", 32'(done), 32'd0);
    step();
    chk_out("halt_held2", 0, 0);
    chk("halt_not_done2", 32'(done), 32'd0);
    instr_ready = 1'b1;
    step();
    chk("halt_drained_valid", 32'(instr_valid), 32'd0);
    chk("halt_drained_count", 32'(fetch_count), 32'd1);
    chk("halt_drained_done",  32'(done),        32'd1);

    // Reset asserted mid-handshake
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_out("rst_w0", 0, 0);
    step(); chk_out("rst_w1", 1, 1);
    instr_ready = 1'b0;
    step(); chk_out("rst_hold", 1, 1);
    chk("rst_hold_addr", 32'(imem_addr), 32'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset("midreset");
    step();
    rst_n = 1'b1; instr_ready = 1'b1;
    step(); step();
    chk_reset("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller that owns the program counter and drives the address of the asynchronous-read instruction memory. It registers each fetched word into a one-entry output stage and hands it to decode over a valid/ready handshake. It also handles branch redirects, halt requests and the end of program memory, and counts retired fetches. It sits between the instruction memory and the decode stage of the MIPS datapath.

## Interface
- ADDR_WIDTH, 6: instruction memory address width, giving 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction word width.
- RESET_PC, 0: first fetch address after reset and after each start.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  pulse that starts fetching from RESET_PC; honoured only in IDLE or DONE.
- imem_addr  out  ADDR_WIDTH  address to the instruction memory; always equals the internal pc.
- imem_data  in  DATA_WIDTH  instruction word from the memory, valid in the same cycle as imem_addr.
- instr  out  DATA_WIDTH  registered instruction.
- instr_pc  out  ADDR_WIDTH  address that instr was fetched from.
- instr_valid  out  1  the output stage holds an instruction.
- instr_ready  in  1  decode accepts; a transfer occurs when instr_valid and instr_ready are both 1.
- redirect  in  1  flush plus PC load, from the branch/jump unit.
- redirect_pc  in  ADDR_WIDTH  new fetch address, sampled when redirect is 1.
- halt  in  1  stop issuing new fetches.
- done  out  1  the sequencer is in DONE.
- fetch_count  out  16  number of transfers since the last start; wraps modulo 2**16.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset (asynchronous): state=IDLE, pc=RESET_PC, instr_valid=0, instr=0, instr_pc=0, done=0, fetch_count=0.
- IDLE:
  - No fetches.
  - start moves to RUN and sets pc=RESET_PC and fetch_count=0.
- RUN, fetch condition: a fetch is a load when the output stage is free, i.e. instr_valid==0 or a transfer occurs this cycle.
- RUN, on a load: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
- RUN, last word: if the load fetches address 2**ADDR_WIDTH-1, pc is not incremented (no wrap) and the state moves to DRAIN.
- RUN, no load: if the stage is occupied and there is no transfer, all registers hold.
- RUN, output empties: a transfer with no load clears instr_valid.
- DRAIN:
  - No new fetches.
  - A transfer clears instr_valid.
  - Go to DONE in the first cycle where instr_valid==0, or where a transfer occurs.
- DONE:
  - done=1 and instr_valid=0.
  - start behaves as in IDLE (goes to RUN, clears fetch_count).
- redirect in RUN or DRAIN:
  - Same edge: instr_valid<=0, pc<=redirect_pc, state<=RUN. No load happens that cycle.
  - A transfer in the same cycle still completes and is counted.
- redirect in IDLE or DONE is ignored.
- halt in RUN moves to DRAIN; no load happens that cycle. halt in any other state is ignored.
- redirect and halt together in RUN: pc<=redirect_pc and instr_valid<=0, and the state goes to DRAIN, then to DONE on the next cycle.
- fetch_count increments by 1 on every transfer.

## Timing
- imem_addr is combinational from the pc register, so memory data is captured on the same edge.
- Start latency: start sampled at edge 0; RUN from edge 0; first instr_valid=1 after edge 1, with instr_pc=RESET_PC.
- Throughput with instr_ready held at 1: one instruction per cycle, with consecutive instr_pc values.
- Backpressure: instr, instr_pc and instr_valid stay stable while instr_valid=1 and instr_ready=0. pc holds.
- Redirect: sampled at edge t; instr_valid=0 during cycle t+1; the instruction from redirect_pc is valid after edge t+1.
- Halt: sampled at edge t; an instruction already held stays valid until it is transferred; done=1 the cycle after the output stage empties.
- Outputs change only on clk or on reset assertion. Reset takes effect regardless of state, including mid-handshake.

## Test plan
- Reset then start, instr_ready=1, memory word k = k: instr_pc 0,1,2,… with instr=k on consecutive cycles; fetch_count=10 after 10 transfers.
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=4 is held: instr and instr_pc stay at word 4, pc stays 5; after release the next instr_pc is 5, with no skip or duplicate.
- Redirect to 0x20 while instr_pc=7 is valid and ready=0: instr_valid=0 for one cycle, then instr_pc=0x20, then 0x21; word 7 is never transferred and fetch_count does not include it.
- End of memory: fetch up to address 63 with ADDR_WIDTH=6: word 63 is transferred, done=1 on the next cycle, no fetch of address 0; start restarts at RESET_PC with fetch_count=0.
- halt and redirect in the same cycle: no further instr_valid, and done=1 two cycles later; a later start fetches from RESET_PC.
- rst_n pulsed low mid-stream (instr_valid=1, ready=0): all outputs return to reset values immediately, and no fetches occur until start.
